// File: rtl/rr_mux_arb_pkg.sv
// Shared types for the round-robin mux arbiter (burst locking enabled by RR_MUX_BURST_EN).
package rr_mux_arb_pkg;

  localparam int unsigned N_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] onehot(input sel_t idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first set request bit scanning ptr, ptr+1, ... mod 4.
module rr_pick_4
  import rr_mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output logic [N_REQ-1:0] gnt,
  output sel_t             gnt_idx,
  output logic             any
);

  logic found;
  sel_t idx;

  always_comb begin
    found   = 1'b0;
    idx     = ptr;
    gnt_idx = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = sel_t'(ptr + sel_t'(k));
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt = found ? onehot(gnt_idx) : '0;
    any = found;
  end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Four valid/ready requesters sharing one registered 4:1 mux stage via round-robin.
// Define RR_MUX_BURST_EN to add req_last and burst locking capped at MAX_BURST beats.
module rr_mux_arbiter_4
  import rr_mux_arb_pkg::*;
#(
  parameter int unsigned W         = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
`ifdef RR_MUX_BURST_EN
  input  logic [N_REQ-1:0] req_last,
`endif
  output logic [W-1:0]     y,
  output sel_t             sel,
  output logic             out_valid,
  input  logic             out_ready
);

  if (MAX_BURST < 1) begin : g_bad_cfg
    $error("MAX_BURST must be at least 1");
  end

  logic             adv;
  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] lock_mask;
  logic             any;
  sel_t             gnt_idx;
  sel_t             ptr;
  sel_t             ptr_next;
  logic [W-1:0]     dmux;

  // Stage can take a new beat when empty or being drained this cycle
  assign adv       = !out_valid || out_ready;
  assign req_eff   = req_valid & lock_mask & {N_REQ{adv && rst_n}};
  assign req_ready = gnt;

  rr_pick_4 u_pick (
    .req     (req_eff),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    dmux = d0;
    case (gnt_idx)
      2'd0:    dmux = d0;
      2'd1:    dmux = d1;
      2'd2:    dmux = d2;
      default: dmux = d3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      sel       <= '0;
    end else if (adv) begin
      out_valid <= any;
      if (any) begin
        y   <= dmux;
        sel <= gnt_idx;
      end
    end
  end

`ifdef RR_MUX_BURST_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state;
  arb_state_e       state_next;
  sel_t             owner;
  sel_t             owner_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             last_w;

  assign last_w = req_last[gnt_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      owner <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      cnt   <= cnt_next;
      ptr   <= ptr_next;
    end
  end

  // The beat that opens a burst counts as its first beat
  always_comb begin
    state_next = state;
    owner_next = owner;
    cnt_next   = cnt;
    ptr_next   = ptr;
    case (state)
      ARB_IDLE: begin
        if (any) begin
          if (last_w || MAX_BURST <= 1) begin
            ptr_next = sel_t'(gnt_idx + 2'd1);
          end else begin
            state_next = ARB_LOCK;
            owner_next = gnt_idx;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      ARB_LOCK: begin
        if (any) begin
          cnt_next = CNT_W'(cnt + CNT_W'(1));
          if (last_w || cnt_next == CNT_W'(MAX_BURST)) begin
            state_next = ARB_IDLE;
            ptr_next   = sel_t'(owner + 2'd1);
            cnt_next   = '0;
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    lock_mask = '1;
    if (state == ARB_LOCK) lock_mask = onehot(owner);
  end
`else
  assign lock_mask = '1;

  always_comb begin
    ptr_next = ptr;
    if (any) ptr_next = sel_t'(gnt_idx + 2'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_next;
  end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Bench for rr_mux_arbiter_4: directed vector tables plus random traffic against a reference model.
// Burst-lock vectors are compiled in when RR_MUX_BURST_EN is defined.
module tb_rr_mux_arbiter_4;

  localparam int MAXB = 8;

  typedef struct {
    logic       rst;
    logic [3:0] rv;
    logic       ordy;
    logic [3:0] d3v;
    logic [3:0] lst;
    logic [3:0] er;
    logic       ev;
    logic [1:0] es;
    logic [3:0] ey;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [3:0] y;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready;
`ifdef RR_MUX_BURST_EN
  logic [3:0] last;
`endif

  int passed = 0;
  int total  = 0;

  // Reference model state
  int         m_ptr;
  logic       m_valid;
  logic [3:0] m_y;
  logic [1:0] m_sel;
  bit         m_lock;
  int         m_owner;
  int         m_cnt;

  rr_mux_arbiter_4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .req_valid (req_valid),
    .req_ready (req_ready),
`ifdef RR_MUX_BURST_EN
    .req_last  (last),
`endif
    .y         (y),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    else passed++;
  endtask

  function automatic logic [3:0] dval(input int w);
    case (w)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  // Expected grant from the arbitration rules for the current inputs
  function automatic logic [3:0] model_ready();
    int w;
    if (rst_n !== 1'b1) return 4'b0000;
    if (m_valid && !out_ready) return 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w = (m_ptr + i) % 4;
      if (m_lock && w != m_owner) continue;
      if (req_valid[w]) return 4'b0001 << w;
    end
    return 4'b0000;
  endfunction

  task automatic model_edge(input logic [3:0] rdy);
    int w;
    if (rst_n !== 1'b1) begin
      m_valid = 1'b0; m_y = 4'h0; m_sel = 2'd0; m_ptr = 0;
      m_lock = 1'b0; m_owner = 0; m_cnt = 0;
    end else if (!m_valid || out_ready) begin
      if (rdy == 4'b0000) begin
        m_valid = 1'b0;
      end else begin
        w = 0;
        for (int i = 0; i < 4; i++) if (rdy[i]) w = i;
        m_valid = 1'b1;
        m_y     = dval(w);
        m_sel   = 2'(w);
`ifdef RR_MUX_BURST_EN
        if (!m_lock) begin
          if (last[w] || MAXB == 1) m_ptr = (w + 1) % 4;
          else begin m_lock = 1'b1; m_owner = w; m_cnt = 1; end
        end else begin
          m_cnt++;
          if (last[w] || m_cnt == MAXB) begin
            m_lock = 1'b0;
            m_ptr  = (m_owner + 1) % 4;
          end
        end
`else
        m_ptr = (w + 1) % 4;
`endif
      end
    end
  endtask

  // One clock: grant checked before the edge, output stage checked just after it
  task automatic tick(input bit use_tab, input vec_t v);
    logic [3:0] er;
    #2;
    er = model_ready();
    chk("req_ready/model", req_ready, er);
    if (use_tab) chk("req_ready/vec", req_ready, v.er);
    @(posedge clk);
    model_edge(er);
    #1;
    chk("out_valid/model", {3'b000, out_valid}, {3'b000, m_valid});
    chk("sel/model", {2'b00, sel}, {2'b00, m_sel});
    chk("y/model", y, m_y);
    if (use_tab) begin
      chk("out_valid/vec", {3'b000, out_valid}, {3'b000, v.ev});
      chk("sel/vec", {2'b00, sel}, {2'b00, v.es});
      chk("y/vec", y, v.ey);
    end
  endtask

  function automatic vec_t row(input logic r, input logic [3:0] rv, input logic o,
                               input logic [3:0] dx, input logic [3:0] l, input logic [3:0] er,
                               input logic ev, input logic [1:0] es, input logic [3:0] ey);
    vec_t v;
    v.rst = r; v.rv = rv; v.ordy = o; v.d3v = dx; v.lst = l;
    v.er = er; v.ev = ev; v.es = es; v.ey = ey;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n = v.rst; req_valid = v.rv; out_ready = v.ordy; d3 = v.d3v;
`ifdef RR_MUX_BURST_EN
    last = v.lst;
`endif
    tick(1'b1, v);
  endtask

  vec_t tv[21];
  vec_t bv[16];
  vec_t nv;

  initial begin
    logic [3:0] xv;
    xv = 4'bxxxx;
    nv = row(1'b1, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    m_ptr = 0; m_valid = 1'b0; m_y = 4'h0; m_sel = 2'd0;
    m_lock = 1'b0; m_owner = 0; m_cnt = 0;
    d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
    rst_n = 1'b0; req_valid = 4'h0; out_ready = 1'b1;
`ifdef RR_MUX_BURST_EN
    last = 4'hf;
`endif

    // reset, rotation, ptr=3 with lone req2, stall, idle, X isolation, mid-stream reset
    tv[0]  = row(1'b0, 4'hf, 1'b1, 4'hd, 4'hf, 4'h0, 1'b0, 2'd0, 4'h0);
    tv[1]  = row(1'b1, 4'hf, 1'b1, 4'hd, 4'hf, 4'h1, 1'b1, 2'd0, 4'ha);
    tv[2]  = row(1'b1, 4'hf, 1'b1, 4'hd, 4'hf, 4'h2, 1'b1, 2'd1, 4'hb);
    tv[3]  = row(1'b1, 4'hf, 1'b1, 4'hd, 4'hf, 4'h4, 1'b1, 2'd2, 4'hc);
    tv[4]  = row(1'b1, 4'hf, 1'b1, 4'hd, 4'hf, 4'h8, 1'b1, 2'd3, 4'hd);
    tv[5]  = row(1'b1, 4'hf, 1'b1, 4'hd, 4'hf, 4'h1, 1'b1, 2'd0, 4'ha);
    tv[6]  = row(1'b1, 4'h4, 1'b1, 4'hd, 4'hf, 4'h4, 1'b1, 2'd2, 4'hc);
    tv[7]  = row(1'b1, 4'h4, 1'b1, 4'hd, 4'hf, 4'h4, 1'b1, 2'd2, 4'hc);
    tv[8]  = row(1'b1, 4'h1, 1'b1, 4'hd, 4'hf, 4'h1, 1'b1, 2'd0, 4'ha);
    tv[9]  = row(1'b1, 4'hf, 1'b0, 4'hd, 4'hf, 4'h0, 1'b1, 2'd0, 4'ha);
    tv[10] = row(1'b1, 4'hf, 1'b0, 4'hd, 4'hf, 4'h0, 1'b1, 2'd0, 4'ha);
    tv[11] = row(1'b1, 4'hf, 1'b0, 4'hd, 4'hf, 4'h0, 1'b1, 2'd0, 4'ha);
    tv[12] = row(1'b1, 4'hf, 1'b1, 4'hd, 4'hf, 4'h2, 1'b1, 2'd1, 4'hb);
    tv[13] = row(1'b1, 4'h0, 1'b1, 4'hd, 4'hf, 4'h0, 1'b0, 2'd1, 4'hb);
    tv[14] = row(1'b1, 4'h7, 1'b1, xv,   4'hf, 4'h4, 1'b1, 2'd2, 4'hc);
    tv[15] = row(1'b1, 4'h7, 1'b1, xv,   4'hf, 4'h1, 1'b1, 2'd0, 4'ha);
    tv[16] = row(1'b1, 4'h8, 1'b1, xv,   4'hf, 4'h8, 1'b1, 2'd3, xv);
    tv[17] = row(1'b1, 4'hf, 1'b1, 4'hd, 4'hf, 4'h1, 1'b1, 2'd0, 4'ha);
    tv[18] = row(1'b1, 4'hf, 1'b1, 4'hd, 4'hf, 4'h2, 1'b1, 2'd1, 4'hb);
    tv[19] = row(1'b0, 4'hf, 1'b1, 4'hd, 4'hf, 4'h0, 1'b0, 2'd0, 4'h0);
    tv[20] = row(1'b1, 4'hf, 1'b1, 4'hd, 4'hf, 4'h1, 1'b1, 2'd0, 4'ha);

    // burst of 3 from req1, then forced release of req0 after MAXB beats with one bubble
    bv[0]  = row(1'b0, 4'hf, 1'b1, 4'hd, 4'hf, 4'h0, 1'b0, 2'd0, 4'h0);
    bv[1]  = row(1'b1, 4'h1, 1'b1, 4'hd, 4'h1, 4'h1, 1'b1, 2'd0, 4'ha);
    bv[2]  = row(1'b1, 4'h7, 1'b1, 4'hd, 4'h0, 4'h2, 1'b1, 2'd1, 4'hb);
    bv[3]  = row(1'b1, 4'h7, 1'b1, 4'hd, 4'h0, 4'h2, 1'b1, 2'd1, 4'hb);
    bv[4]  = row(1'b1, 4'h7, 1'b1, 4'hd, 4'h2, 4'h2, 1'b1, 2'd1, 4'hb);
    bv[5]  = row(1'b1, 4'h7, 1'b1, 4'hd, 4'h4, 4'h4, 1'b1, 2'd2, 4'hc);
    for (int i = 6; i < 9; i++)
      bv[i] = row(1'b1, 4'h3, 1'b1, 4'hd, 4'h0, 4'h1, 1'b1, 2'd0, 4'ha);
    bv[9]  = row(1'b1, 4'h2, 1'b1, 4'hd, 4'h0, 4'h0, 1'b0, 2'd0, 4'ha);
    for (int i = 10; i < 15; i++)
      bv[i] = row(1'b1, 4'h3, 1'b1, 4'hd, 4'h0, 4'h1, 1'b1, 2'd0, 4'ha);
    bv[15] = row(1'b1, 4'h3, 1'b1, 4'hd, 4'h0, 4'h2, 1'b1, 2'd1, 4'hb);

    for (int i = 0; i < 21; i++) apply(tv[i]);

`ifdef RR_MUX_BURST_EN
    d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
    for (int i = 0; i < 16; i++) apply(bv[i]);
`endif

    // Random traffic with occasional resets and consumer stalls
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      req_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
`ifdef RR_MUX_BURST_EN
      last = 4'($urandom) & 4'($urandom);
`endif
      tick(1'b0, nv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
